// File: rtl/esc_arm_seq_if.sv
// -----------------------------------------------------------------------------
// esc_arm_seq_if
// Bundle between the flight-control loop and the ESC arming/sequencing block.
//
// Handshake: arm_req, disarm_req and cmd_vld are single-cycle strobes with no
// back-pressure. The controller samples them on every rising clock edge and
// acts on them in that same cycle. cmd_* only need to be valid while cmd_vld
// is high.
//
// Signals
//   arm_req, disarm_req   master -> slave  request pulses
//   cmd_vld, cmd_*        master -> slave  target speeds (11-bit)
//   *_spd                 slave  -> master registered speeds to the ESC block
//   motors_off            slave  -> master 1 forces the ESC block to zero
//   armed, fault          slave  -> master registered status flags
//   dbg_state             slave  -> master current FSM state (debug)
//
// Modports
//   master : flight-control side (drives the requests and commands)
//   slave  : controller side (esc_arm_seq)
// -----------------------------------------------------------------------------
interface esc_arm_seq_if;
   logic        arm_req;
   logic        disarm_req;
   logic        cmd_vld;
   logic [10:0] cmd_frnt;
   logic [10:0] cmd_bck;
   logic [10:0] cmd_lft;
   logic [10:0] cmd_rght;
   logic [10:0] frnt_spd;
   logic [10:0] bck_spd;
   logic [10:0] lft_spd;
   logic [10:0] rght_spd;
   logic        motors_off;
   logic        armed;
   logic        fault;
   logic [2:0]  dbg_state;

   modport master (
      output arm_req, disarm_req, cmd_vld,
      output cmd_frnt, cmd_bck, cmd_lft, cmd_rght,
      input  frnt_spd, bck_spd, lft_spd, rght_spd,
      input  motors_off, armed, fault, dbg_state
   );

   modport slave (
      input  arm_req, disarm_req, cmd_vld,
      input  cmd_frnt, cmd_bck, cmd_lft, cmd_rght,
      output frnt_spd, bck_spd, lft_spd, rght_spd,
      output motors_off, armed, fault, dbg_state
   );
endinterface

// File: rtl/esc_arm_seq.sv
// -----------------------------------------------------------------------------
// esc_arm_seq
// Arming and sequencing controller in front of the four-channel ESC PWM block.
// It holds a zero-throttle arm window, then slew-limits the four speed outputs
// toward the latched flight-controller targets. It forces the motors off on
// disarm, or when the command watchdog expires.
//
// Ports
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    esc_arm_seq_if.slave (requests, commands, speeds, status, dbg_state)
//
// Channel order inside the packed arrays: 0 front, 1 back, 2 left, 3 right.
//
// Build option
//   SOFT_STOP_EN : when defined, a disarm in RUN enters STOPPING. In STOPPING
//                  the speeds ramp down to zero at the normal slew rate, and
//                  the block then goes to IDLE. When the macro is not defined,
//                  a disarm in RUN goes straight to IDLE.
// -----------------------------------------------------------------------------
module esc_arm_seq #(
   parameter int ARM_CYC   = 25000000,
   parameter int SLEW_DIV  = 50000,
   parameter int SLEW_STEP = 8,
   parameter int WDOG_CYC  = 2500000,
   parameter int SPD_MAX   = 1500
) (
   input logic          clk,
   input logic          rst_n,
   esc_arm_seq_if.slave bus
);

   localparam int ARM_W = (ARM_CYC  > 1) ? $clog2(ARM_CYC)  : 1;
   localparam int DIV_W = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
   localparam int WD_W  = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;

   localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYC - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLEW_DIV - 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WDOG_CYC - 1);
   localparam logic [10:0]      STEP     = 11'(SLEW_STEP);
   localparam logic [10:0]      SPD_LIM  = 11'(SPD_MAX);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ARMING   = 3'd1,
      ST_RUN      = 3'd2,
`ifdef SOFT_STOP_EN
      ST_FAULT    = 3'd3,
      ST_STOPPING = 3'd4
`else
      ST_FAULT    = 3'd3
`endif
   } state_t;

   state_t            state_q, state_d;
   logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic [3:0][10:0]  tgt_q, tgt_d;
   logic [3:0][10:0]  spd_q, spd_d;
   logic              motors_off_q, motors_off_d;
   logic              armed_q, armed_d;
   logic              fault_q, fault_d;
   logic [3:0][10:0]  cmd;
   logic              tick;

   assign cmd = {bus.cmd_rght, bus.cmd_lft, bus.cmd_bck, bus.cmd_frnt};

   // The distance to the target is compared before any add or subtract. The
   // result therefore never passes the target, and so never wraps past 0 or
   // past SPD_MAX.
   function automatic logic [10:0] slew_step(input logic [10:0] cur,
                                             input logic [10:0] tgt);
      logic [10:0] r;
      if (tgt >= cur) begin
         r = ((tgt - cur) <= STEP) ? tgt : cur + STEP;
      end else begin
         r = ((cur - tgt) <= STEP) ? tgt : cur - STEP;
      end
      return r;
   endfunction

   function automatic logic [10:0] clamp(input logic [10:0] v);
      return (v > SPD_LIM) ? SPD_LIM : v;
   endfunction

   always_comb begin
      state_d   = state_q;
      arm_cnt_d = arm_cnt_q;
      div_d     = div_q;
      wd_d      = wd_q;
      tgt_d     = tgt_q;
      spd_d     = spd_q;
      tick      = (div_q == DIV_LAST);

      case (state_q)
         ST_IDLE: begin
            // A disarm pulse in the same cycle wins over the arm request.
            if (!bus.disarm_req && bus.arm_req) begin
               state_d   = ST_ARMING;
               arm_cnt_d = '0;
            end
         end

         ST_ARMING: begin
            // A repeated arm_req is deliberately not looked at here.
            if (bus.disarm_req) begin
               state_d = ST_IDLE;
            end else if (arm_cnt_q == ARM_LAST) begin
               state_d = ST_RUN;
               div_d   = '0;
               wd_d    = '0;
            end else begin
               arm_cnt_d = arm_cnt_q + ARM_W'(1);
            end
         end

         ST_RUN: begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
            if (tick) begin
               for (int i = 0; i < 4; i++) spd_d[i] = slew_step(spd_q[i], tgt_q[i]);
            end
            if (bus.disarm_req) begin
`ifdef SOFT_STOP_EN
               state_d = ST_STOPPING;
               tgt_d   = '0;
`else
               state_d = ST_IDLE;
`endif
            end else if (!bus.cmd_vld && (wd_q == WD_LAST)) begin
               state_d = ST_FAULT;
            end else if (bus.cmd_vld) begin
               for (int i = 0; i < 4; i++) tgt_d[i] = clamp(cmd[i]);
               wd_d = '0;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end

`ifdef SOFT_STOP_EN
         ST_STOPPING: begin
            // Ramp down at the normal slew rate. The watchdog is not running here.
            tgt_d = '0;
            div_d = tick ? '0 : div_q + DIV_W'(1);
            if (tick) begin
               for (int i = 0; i < 4; i++) spd_d[i] = slew_step(spd_q[i], tgt_q[i]);
            end
            if (bus.disarm_req || (spd_q == '0)) begin
               state_d = ST_IDLE;
            end
         end
`endif

         ST_FAULT: begin
            if (bus.disarm_req) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // IDLE and FAULT always present zero speed, and they wipe the targets.
      if ((state_d == ST_IDLE) || (state_d == ST_FAULT)) begin
         spd_d = '0;
         tgt_d = '0;
      end

      // The status flags are computed from the next state. They therefore
      // update on the same edge as the state register.
      motors_off_d = (state_d == ST_IDLE) || (state_d == ST_FAULT);
      armed_d      = (state_d == ST_RUN);
      fault_d      = (state_d == ST_FAULT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         arm_cnt_q    <= '0;
         div_q        <= '0;
         wd_q         <= '0;
         tgt_q        <= '0;
         spd_q        <= '0;
         motors_off_q <= 1'b1;
         armed_q      <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         arm_cnt_q    <= arm_cnt_d;
         div_q        <= div_d;
         wd_q         <= wd_d;
         tgt_q        <= tgt_d;
         spd_q        <= spd_d;
         motors_off_q <= motors_off_d;
         armed_q      <= armed_d;
         fault_q      <= fault_d;
      end
   end

   assign bus.frnt_spd   = spd_q[0];
   assign bus.bck_spd    = spd_q[1];
   assign bus.lft_spd    = spd_q[2];
   assign bus.rght_spd   = spd_q[3];
   assign bus.motors_off = motors_off_q;
   assign bus.armed      = armed_q;
   assign bus.fault      = fault_q;
   assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_esc_arm_seq.sv
// -----------------------------------------------------------------------------
// tb_esc_arm_seq
// Directed bench for esc_arm_seq. It uses small parameters: arm window 10,
// slew divider 4, step 8, watchdog 100, clamp 1500. After RUN is entered, the
// slew ticks fall on the 4th, 8th, 12th ... edge. All edge arithmetic below
// counts from that entry edge (R0). Inputs change 1 time unit after a rising
// edge, and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_esc_arm_seq;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ARMING   = 3'd1;
   localparam logic [2:0] S_RUN      = 3'd2;
   localparam logic [2:0] S_FAULT    = 3'd3;
`ifdef SOFT_STOP_EN
   localparam logic [2:0] S_STOPPING = 3'd4;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   esc_arm_seq_if bus ();

   esc_arm_seq #(
      .ARM_CYC   (10),
      .SLEW_DIV  (4),
      .SLEW_STEP (8),
      .WDOG_CYC  (100),
      .SPD_MAX   (1500)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [10:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_spd(input string tag, input logic [10:0] v);
      check({tag, " frnt"}, bus.frnt_spd, v);
      check({tag, " bck"},  bus.bck_spd,  v);
      check({tag, " lft"},  bus.lft_spd,  v);
      check({tag, " rght"}, bus.rght_spd, v);
   endtask

   task automatic send_cmd(input logic [10:0] v);
      bus.cmd_vld  = 1'b1;
      bus.cmd_frnt = v;
      bus.cmd_bck  = v;
      bus.cmd_lft  = v;
      bus.cmd_rght = v;
      step(1);
      bus.cmd_vld  = 1'b0;
   endtask

   task automatic pulse_disarm();
      bus.disarm_req = 1'b1;
      step(1);
      bus.disarm_req = 1'b0;
   endtask

   // IDLE -> ARMING -> RUN. The task returns just after the RUN entry edge (R0).
   task automatic go_run(input string tag);
      bus.arm_req = 1'b1;
      step(1);
      bus.arm_req = 1'b0;
      check({tag, " arming motors_off"}, bus.motors_off, 0);
      check({tag, " arming state"}, bus.dbg_state, S_ARMING);
      step(9);
      check({tag, " arming armed"}, bus.armed, 0);
      check_spd({tag, " arming spd"}, 11'd0);
      step(1);
      check({tag, " run armed"}, bus.armed, 1);
      check({tag, " run state"}, bus.dbg_state, S_RUN);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench exceeded its time budget");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n          = 1'b0;
      bus.arm_req    = 1'b0;
      bus.disarm_req = 1'b0;
      bus.cmd_vld    = 1'b0;
      bus.cmd_frnt   = '0;
      bus.cmd_bck    = '0;
      bus.cmd_lft    = '0;
      bus.cmd_rght   = '0;

      // Reset state
      step(2);
      check_spd("rst spd", 11'd0);
      check("rst motors_off", bus.motors_off, 1);
      check("rst armed", bus.armed, 0);
      check("rst fault", bus.fault, 0);
      rst_n = 1'b1;
      step(1);
      check("post rst state", bus.dbg_state, S_IDLE);

      // Arm window and slew up to 20
      go_run("t2");
      send_cmd(11'd20);            // R1
      step(2);                     // R3
      check_spd("t3 pre tick", 11'd0);
      step(1);                     // R4
      check_spd("t3 tick1", 11'd8);
      step(4);                     // R8
      check_spd("t3 tick2", 11'd16);
      step(4);                     // R12
      check_spd("t3 tick3", 11'd20);

      // A target above the clamp is limited to 1500; the speed climbs 8 per tick
      send_cmd(11'd2000);          // R13
      step(3);                     // R16
      check_spd("t3 clamp tick1", 11'd28);
      step(4);                     // R20
      check_spd("t3 clamp tick2", 11'd36);
      step(32);                    // R52
      check_spd("t4 reach 100", 11'd100);

      // A small step lands exactly on the target, then the speed ramps down to 0
      send_cmd(11'd95);            // R53
      step(3);                     // R56
      check_spd("t4 snap 95", 11'd95);
      send_cmd(11'd0);             // R57
      for (int k = 1; k <= 12; k++) exp_q.push_back((95 > 8 * k) ? 11'(95 - 8 * k) : 11'd0);
      step(3);                     // R60
      check_spd("t4 down", exp_q.pop_front());
      while (exp_q.size() > 0) begin
         step(4);
         check_spd("t4 down", exp_q.pop_front());
      end                          // ends at R104 with speed 0
      step(4);                     // R108
      check_spd("t4 no underflow", 11'd0);

      // Watchdog: the last cmd was at R57, so it expires on edge R157
      step(48);                    // R156
      check("t5 pre wdog fault", bus.fault, 0);
      check("t5 pre wdog armed", bus.armed, 1);
      step(1);                     // R157
      check("t5 fault", bus.fault, 1);
      check("t5 motors_off", bus.motors_off, 1);
      check("t5 armed", bus.armed, 0);
      check_spd("t5 spd", 11'd0);
      bus.arm_req = 1'b1;
      step(1);
      bus.arm_req = 1'b0;
      check("t5 arm ignored state", bus.dbg_state, S_FAULT);
      check("t5 arm ignored fault", bus.fault, 1);
      pulse_disarm();
      check("t5 clear state", bus.dbg_state, S_IDLE);
      check("t5 clear fault", bus.fault, 0);
      check("t5 clear motors_off", bus.motors_off, 1);

      // Simultaneous arm and disarm in IDLE
      bus.arm_req    = 1'b1;
      bus.disarm_req = 1'b1;
      step(1);
      bus.arm_req    = 1'b0;
      bus.disarm_req = 1'b0;
      check("t6 arm+disarm state", bus.dbg_state, S_IDLE);
      check("t6 arm+disarm motors_off", bus.motors_off, 1);

      // Disarm at speed 40
      go_run("t6");
      send_cmd(11'd40);            // R1
      step(3);                     // R4
      check_spd("t6 tick1", 11'd8);
      step(16);                    // R20
      check_spd("t6 at 40", 11'd40);
      pulse_disarm();              // R21
`ifdef SOFT_STOP_EN
      check("t6 stopping state", bus.dbg_state, S_STOPPING);
      check("t6 stopping armed", bus.armed, 0);
      check("t6 stopping motors_off", bus.motors_off, 0);
      check_spd("t6 stopping hold", 11'd40);
      exp_q.push_back(11'd32);
      exp_q.push_back(11'd24);
      exp_q.push_back(11'd16);
      exp_q.push_back(11'd8);
      exp_q.push_back(11'd0);
      step(3);                     // R24
      check_spd("t6 ramp", exp_q.pop_front());
      while (exp_q.size() > 0) begin
         step(4);
         check_spd("t6 ramp", exp_q.pop_front());
      end                          // ends at R40
      check("t6 still stopping", bus.dbg_state, S_STOPPING);
      step(1);                     // R41
      check("t6 soft idle state", bus.dbg_state, S_IDLE);
      check("t6 soft idle motors_off", bus.motors_off, 1);
`else
      check("t6 disarm state", bus.dbg_state, S_IDLE);
      check("t6 disarm motors_off", bus.motors_off, 1);
      check("t6 disarm armed", bus.armed, 0);
      check_spd("t6 disarm spd", 11'd0);
`endif

      // Reset mid-RUN at speed 200
      go_run("t1");
      send_cmd(11'd200);           // R1
      step(3);                     // R4
      check_spd("t1 tick1", 11'd8);
      for (int k = 0; k < 24; k++) begin
         send_cmd(11'd200);
         step(3);
      end                          // R100
      check_spd("t1 at 200", 11'd200);
      rst_n = 1'b0;
      #2;
      check_spd("t1 async spd", 11'd0);
      check("t1 async motors_off", bus.motors_off, 1);
      check("t1 async armed", bus.armed, 0);
      #5;
      rst_n = 1'b1;
      step(1);
      check("t1 post rst state", bus.dbg_state, S_IDLE);
      check("t1 post rst motors_off", bus.motors_off, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
